// File: rtl/max7219_spi_receiver_if.sv
// Pin and register-shadow bundle between a MAX7219 command source and the receiver.
// The master drives the three SPI pins; the slave drives the decoded register file.
interface max7219_spi_receiver_if;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic [63:0] rows;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic [3:0]  last_addr;
  logic [7:0]  last_data;
  logic        frame_valid;
  logic        frame_error;

  modport master (
    output sclk, mosi, cs_n,
    input  rows, decode_mode, intensity, scan_limit, shutdown_n, display_test,
    input  last_addr, last_data, frame_valid, frame_error
  );

  modport slave (
    input  sclk, mosi, cs_n,
    output rows, decode_mode, intensity, scan_limit, shutdown_n, display_test,
    output last_addr, last_data, frame_valid, frame_error
  );
endinterface

// File: rtl/max7219_spi_receiver.sv
// Oversampling SPI slave that decodes MAX7219 16-bit frames into a shadow register file.
// All logic runs on clk; sclk/mosi/cs_n are only ever sampled through synchronisers.
module max7219_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  max7219_spi_receiver_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [4:0] L_FRAME_BITS = 5'(FRAME_BITS);
  localparam logic [4:0] L_COUNT_MAX  = 5'd31;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_shift;
  logic [15:0] w_shift_next;
  logic [4:0]  r_count;
  logic [4:0]  w_count_next;

  logic        w_sclk_rise;
  logic        w_cs_rise;
  logic        w_cs_fall;
  logic        w_mosi;
  logic        w_commit_ok;
  logic        w_commit_err;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;

  logic [7:0]  r_rows [8];
  logic [7:0]  r_decode_mode;
  logic [3:0]  r_intensity;
  logic [2:0]  r_scan_limit;
  logic        r_shutdown_n;
  logic        r_display_test;
  logic [3:0]  r_last_addr;
  logic [7:0]  r_last_data;
  logic        r_frame_valid;
  logic        r_frame_error;

  // Index 0 is the newest sample; idle levels are sclk=1, cs_n=1, mosi=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_rise   = r_cs_sync[SYNC_STAGES-2]   & ~r_cs_sync[SYNC_STAGES-1];
  assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-2]  &  r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_shift_next = '0;
          w_count_next = '0;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A simultaneous sclk rise is dropped when the frame closes.
        if (w_cs_rise) begin
          w_state_next = S_COMMIT;
        end else if (w_sclk_rise) begin
          w_shift_next = (r_shift << 1) | {15'd0, w_mosi};
          if (r_count != L_COUNT_MAX) begin
            w_count_next = r_count + 5'd1;
          end
        end
      end
      S_COMMIT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_commit_ok  = (r_state == S_COMMIT) && (r_count == L_FRAME_BITS);
  assign w_commit_err = (r_state == S_COMMIT) && (r_count != L_FRAME_BITS);
  assign w_addr       = r_shift[11:8];
  assign w_data       = r_shift[7:0];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_rows[gi] <= '0;
        end else if (w_commit_ok && (w_addr == 4'(gi + 1))) begin
          r_rows[gi] <= w_data;
        end
      end
      assign bus.rows[8*gi +: 8] = r_rows[gi];
    end
  endgenerate

  // Addresses 0x0, 0xD and 0xE only refresh last_addr/last_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_decode_mode  <= '0;
      r_intensity    <= '0;
      r_scan_limit   <= '0;
      r_shutdown_n   <= 1'b0;
      r_display_test <= 1'b0;
      r_last_addr    <= '0;
      r_last_data    <= '0;
      r_frame_valid  <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_frame_valid <= w_commit_ok;
      r_frame_error <= w_commit_err;
      if (w_commit_ok) begin
        r_last_addr <= w_addr;
        r_last_data <= w_data;
        case (w_addr)
          4'h9:    r_decode_mode  <= w_data;
          4'hA:    r_intensity    <= w_data[3:0];
          4'hB:    r_scan_limit   <= w_data[2:0];
          4'hC:    r_shutdown_n   <= w_data[0];
          4'hF:    r_display_test <= w_data[0];
          default: ;
        endcase
      end
    end
  end

  assign bus.decode_mode  = r_decode_mode;
  assign bus.intensity    = r_intensity;
  assign bus.scan_limit   = r_scan_limit;
  assign bus.shutdown_n   = r_shutdown_n;
  assign bus.display_test = r_display_test;
  assign bus.last_addr    = r_last_addr;
  assign bus.last_data    = r_last_data;
  assign bus.frame_valid  = r_frame_valid;
  assign bus.frame_error  = r_frame_error;

endmodule

// File: tb/tb_max7219_spi_receiver.sv
// Scoreboarded bench: a frame-level register-file model predicts each commit/reject,
// and a monitor checks every frame_valid/frame_error pulse against the queue.
module tb_max7219_spi_receiver;
  localparam int HALF    = 4;   // sclk = clk/8
  localparam int LATENCY = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max7219_spi_receiver_if bus();

  max7219_spi_receiver #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          ok;
    logic [3:0]  la;
    logic [7:0]  ld;
    logic [63:0] rows;
    logic [7:0]  dec;
    logic [3:0]  inten;
    logic [2:0]  scan;
    logic        sd;
    logic        dt;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] m_rows [8];
  logic [7:0] m_dec;
  logic [3:0] m_inten;
  logic [2:0] m_scan;
  logic       m_sd;
  logic       m_dt;
  logic [3:0] m_la;
  logic [7:0] m_ld;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] model_rows();
    logic [63:0] p;
    for (int r = 0; r < 8; r++) p[8*r +: 8] = m_rows[r];
    return p;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
    m_dec = 0; m_inten = 0; m_scan = 0; m_sd = 0; m_dt = 0; m_la = 0; m_ld = 0;
  endtask

  // Frame-level rule: a frame is good iff exactly 16 sclk rises were counted
  // (a rise coinciding with the cs_n rise is lost); the kept word is the first 16 bits sent.
  task automatic predict(input logic [31:0] w, input int n, input bit collide);
    exp_t e;
    int   eff;
    logic [31:0] word;
    eff = collide ? n - 1 : n;
    e.ok = (eff == 16);
    if (e.ok) begin
      word = w >> (n - 16);
      m_la = word[11:8];
      m_ld = word[7:0];
      if (m_la >= 4'h1 && m_la <= 4'h8) m_rows[m_la - 4'h1] = m_ld;
      else if (m_la == 4'h9) m_dec = m_ld;
      else if (m_la == 4'hA) m_inten = m_ld[3:0];
      else if (m_la == 4'hB) m_scan = m_ld[2:0];
      else if (m_la == 4'hC) m_sd = m_ld[0];
      else if (m_la == 4'hF) m_dt = m_ld[0];
    end
    e.la = m_la; e.ld = m_ld; e.rows = model_rows(); e.dec = m_dec;
    e.inten = m_inten; e.scan = m_scan; e.sd = m_sd; e.dt = m_dt;
    e.due = cyc + LATENCY;
    sb.push_back(e);
    $display("frame: bits=%0h n=%0d collide=%0b expect %s addr=%0h data=%0h",
             w, n, collide, e.ok ? "valid" : "error", e.la, e.ld);
  endtask

  task automatic send(input logic [31:0] w, input int n, input bit collide);
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = w[i];
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      if (i == 0 && collide) begin
        bus.cs_n = 1'b1;
        predict(w, n, collide);
      end
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    if (!collide || n == 0) begin
      repeat (HALF) @(negedge clk);
      bus.cs_n = 1'b1;
      predict(w, n, 1'b0);
    end
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rows"}, bus.rows, 64'd0);
    chk({tag, "_regs"}, {bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown_n,
                         bus.display_test, bus.last_addr, bus.last_data}, 64'd0);
    chk({tag, "_pulses"}, {bus.frame_valid, bus.frame_error}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset && (bus.frame_valid || bus.frame_error)) begin
      chk("valid_error_exclusive", 64'(bus.frame_valid & bus.frame_error), 64'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: valid=%0b error=%0b, required no event",
                 bus.frame_valid, bus.frame_error);
      end else begin
        mon_e = sb.pop_front();
        chk("frame_valid", 64'(bus.frame_valid), 64'(mon_e.ok));
        chk("latency", 64'(cyc), 64'(mon_e.due));
        chk("last_addr", 64'(bus.last_addr), 64'(mon_e.la));
        chk("last_data", 64'(bus.last_data), 64'(mon_e.ld));
        chk("rows", bus.rows, mon_e.rows);
        chk("ctrl_regs", {bus.decode_mode, bus.intensity, bus.scan_limit, bus.shutdown_n, bus.display_test},
            {mon_e.dec, mon_e.inten, mon_e.scan, mon_e.sd, mon_e.dt});
      end
    end
  end

  logic [15:0] init_seq [5] = '{16'h0C01, 16'h0900, 16'h0A0A, 16'h0B07, 16'h0F00};
  logic [15:0] row_seq  [8] = '{16'h013C, 16'h0242, 16'h0381, 16'h0481,
                                16'h05FF, 16'h0681, 16'h0781, 16'h0800};

  initial begin
    int n;
    bit col;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.cs_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    foreach (init_seq[i]) send({16'h0, init_seq[i]}, 16, 1'b0);
    wait_drain();
    chk("init_shutdown_n", 64'(bus.shutdown_n), 64'd1);
    chk("init_decode", 64'(bus.decode_mode), 64'h00);
    chk("init_intensity", 64'(bus.intensity), 64'hA);
    chk("init_scan_limit", 64'(bus.scan_limit), 64'd7);
    chk("init_display_test", 64'(bus.display_test), 64'd0);

    foreach (row_seq[i]) send({16'h0, row_seq[i]}, 16, 1'b0);
    wait_drain();
    chk("rows_pattern", bus.rows, 64'h00_81_81_FF_81_81_42_3C);
    chk("rows_last", {bus.last_addr, bus.last_data}, 64'h800);

    send(32'h0000_0ABC, 12, 1'b0);
    send(32'h0001_01AA, 17, 1'b0);
    wait_drain();
    chk("bad_len_rows", bus.rows, 64'h00_81_81_FF_81_81_42_3C);

    send(32'h0000_0055, 16, 1'b0);
    wait_drain();
    chk("noop_last_data", 64'(bus.last_data), 64'h55);
    chk("noop_rows", bus.rows, 64'h00_81_81_FF_81_81_42_3C);
    send(32'h0000_F3A5, 16, 1'b0);
    wait_drain();
    chk("upper_nibble_row3", 64'(bus.rows[23:16]), 64'hA5);

    // Reset after 8 bits of 05FF: the partial frame must vanish.
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 15; i >= 8; i--) begin
      bus.mosi = init_seq[0][0] ^ 1'b1 ? 1'b0 : 1'b0;
      bus.mosi = (16'h05FF >> i) & 1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    reset = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_frame_reset");
    repeat (4) @(negedge clk);
    send(32'h0000_0501, 16, 1'b0);
    wait_drain();
    chk("after_reset_rows", bus.rows, 64'h00_00_00_01_00_00_00_00);

    send(32'h0000_0A03, 16, 1'b1);
    wait_drain();
    chk("collide_intensity", 64'(bus.intensity), 64'h0);
    send(32'h0000_0A03, 16, 1'b0);
    wait_drain();
    chk("post_collide_intensity", 64'(bus.intensity), 64'h3);

    for (int t = 0; t < 40; t++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      col = ($urandom_range(0, 9) == 0);
      send($urandom, n, col);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
